// File: rtl/hex_msg_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : hex_msg_scroller
//  Description : Scrolls "HELLO" + 3 blanks across N_DIGITS active-low
//                7-segment displays, one position per divided tick.
//                SW[0] is an asynchronous active-high reset.
//                SW[3:1] select pause, direction and one-shot mode.
//                Optional build macro HEX_DP_MARK_EN lights the decimal point
//                on the digit that shows the first glyph of the message.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_msg_scroller #(
  parameter int TICK_DIV = 50_000_000,
  parameter int N_DIGITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic [3:0]            SW,
  output logic [8*N_DIGITS-1:0] HEX,
  output logic [2:0]            pos,
  output logic                  wrap
);

  localparam int             c_QW     = $clog2(TICK_DIV);
  localparam logic [c_QW-1:0] c_Q_LAST = c_QW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  logic                  w_rst;
  logic [2:0]            r_sw_meta;
  logic [2:0]            r_sw_sync;
  logic                  w_pause;
  logic                  w_dir;
  logic                  w_oneshot;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_pos;
  logic [2:0]            w_pos_nxt;
  logic [c_QW-1:0]       r_q;
  logic [c_QW-1:0]       w_q_nxt;
  logic                  r_wrap;
  logic                  w_wrap_nxt;
  logic [8*N_DIGITS-1:0] r_hex;
  logic [8*N_DIGITS-1:0] w_hex_disp;

  assign w_rst     = SW[0];
  assign w_pause   = r_sw_sync[0];
  assign w_dir     = r_sw_sync[1];
  assign w_oneshot = r_sw_sync[2];

  // Active-high glyph ROM for the 8-entry message.
  function automatic logic [6:0] f_glyph(input logic [2:0] idx);
    logic [6:0] g;
    case (idx)
      3'd0:    g = 7'h76; // H
      3'd1:    g = 7'h79; // E
      3'd2:    g = 7'h38; // L
      3'd3:    g = 7'h38; // L
      3'd4:    g = 7'h3F; // O
      default: g = 7'h00; // blank
    endcase
    return g;
  endfunction

  // One active-low digit: digit k shows message index pos + (N_DIGITS-1-k).
  function automatic logic [7:0] f_digit(input logic [2:0] p, input int k);
    logic [2:0] idx;
    logic [7:0] d;
    idx     = p + 3'(N_DIGITS - 1 - k);
    d[6:0]  = ~f_glyph(idx);
`ifdef HEX_DP_MARK_EN
    d[7]    = (idx != 3'd0);
`else
    d[7]    = 1'b1;
`endif
    return d;
  endfunction

  // Two-flop synchroniser for the mode switches.
  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) begin
      r_sw_meta <= 3'b000;
      r_sw_sync <= 3'b000;
    end else begin
      r_sw_meta <= SW[3:1];
      r_sw_sync <= r_sw_meta;
    end
  end

  // State, position, divider and wrap registers.
  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) begin
      r_state <= ST_RUN;
      r_pos   <= 3'd0;
      r_q     <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_q     <= w_q_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Next-state logic; pause takes priority over a coinciding tick.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_q_nxt     = r_q;
    w_wrap_nxt  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_pause) begin
          w_state_nxt = ST_PAUSE;
          w_q_nxt     = '0;
        end else if (r_q == c_Q_LAST) begin
          w_q_nxt = '0;
          if (!w_dir) begin
            w_pos_nxt  = r_pos + 3'd1;
            w_wrap_nxt = (r_pos == 3'd7);
          end else begin
            w_pos_nxt  = r_pos - 3'd1;
            w_wrap_nxt = (r_pos == 3'd0);
          end
          if (w_wrap_nxt && w_oneshot) begin
            w_state_nxt = ST_DONE;
            w_pos_nxt   = 3'd0;
          end
        end else begin
          w_q_nxt = r_q + c_QW'(1);
        end
      end
      ST_PAUSE: begin
        w_q_nxt = '0;
        if (!w_pause) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        w_q_nxt   = '0;
        w_pos_nxt = 3'd0;
        if (!w_oneshot) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_pos_nxt   = 3'd0;
        w_q_nxt     = '0;
      end
    endcase
  end

  // Display image for the current position; blank once the one-shot is done.
  always_comb begin
    w_hex_disp = '1;
    if (r_state != ST_DONE) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        w_hex_disp[8*k +: 8] = f_digit(r_pos, k);
      end
    end
  end

  // Registered display outputs, one cycle behind the position.
  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) begin
      r_hex <= '1;
    end else begin
      r_hex <= w_hex_disp;
    end
  end

  assign HEX  = r_hex;
  assign pos  = r_pos;
  assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_hex_msg_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_msg_scroller
//  Description : Self-checking bench for hex_msg_scroller (TICK_DIV=4,
//                N_DIGITS=4) against a message-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_msg_scroller;
  localparam int TD = 4;
  localparam int ND = 4;
  localparam int M_RUN = 0, M_PAUSE = 1, M_DONE = 2;

  logic          clk = 1'b0;
  logic [3:0]    SW  = 4'b0001;
  logic [8*ND-1:0] HEX;
  logic [2:0]    pos;
  logic          wrap;

  always #5 clk = ~clk;

  hex_msg_scroller #(.TICK_DIV(TD), .N_DIGITS(ND)) dut (
    .CLOCK_50(clk),
    .SW      (SW),
    .HEX     (HEX),
    .pos     (pos),
    .wrap    (wrap)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int            m_mode;
  int            m_left;   // cycles left until the next scroll step
  logic [2:0]    m_pos;
  logic          m_wrap;
  logic [8*ND-1:0] m_hex;
  logic [2:0]    hist[$];  // switch samples still travelling through sync
  string         msg = "HELLO   ";

  function automatic logic [7:0] seg_of(byte c);
    case (c)
      "H":     return 8'h76;
      "E":     return 8'h79;
      "L":     return 8'h38;
      "O":     return 8'h3F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [8*ND-1:0] disp(int p);
    logic [8*ND-1:0] r;
    logic [7:0] b;
    int idx;
    for (int k = 0; k < ND; k++) begin
      idx = (p + ND - 1 - k) % 8;
      b = ~seg_of(msg[idx]);
`ifdef HEX_DP_MARK_EN
      if (idx == 0) b[7] = 1'b0;
`endif
      r[8*k +: 8] = b;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mode = M_RUN;
    m_left = TD;
    m_pos  = 3'd0;
    m_wrap = 1'b0;
    m_hex  = '1;
    hist.delete();
    hist.push_back(3'b000);
    hist.push_back(3'b000);
  endtask

  // Advance one clock; model follows the switch rules; returns at negedge.
  task automatic cyc();
    logic [2:0] u;
    logic [8*ND-1:0] h;
    @(posedge clk);
    if (SW[0]) begin
      model_reset();
    end else begin
      h = (m_mode == M_DONE) ? '1 : disp(m_pos);
      u = hist.pop_front();
      hist.push_back(SW[3:1]);
      m_wrap = 1'b0;
      case (m_mode)
        M_RUN: begin
          if (u[0]) begin
            m_mode = M_PAUSE;
            m_left = TD;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_left = TD;
              if (!u[1]) begin m_wrap = (m_pos == 3'd7); m_pos = m_pos + 3'd1; end
              else       begin m_wrap = (m_pos == 3'd0); m_pos = m_pos - 3'd1; end
              if (m_wrap && u[2]) begin m_mode = M_DONE; m_pos = 3'd0; end
            end
          end
        end
        M_PAUSE: if (!u[0]) m_mode = M_RUN;
        default: if (!u[2]) begin m_mode = M_RUN; m_pos = 3'd0; m_left = TD; end
      endcase
      m_hex = h;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    SW = 4'b0001;
    model_reset();
    repeat (3) cyc();
    n_checks++; if (HEX !== '1)   begin n_fail++; $display("FAIL reset_hex got=%h exp=%h", HEX, {8*ND{1'b1}}); end
    n_checks++; if (pos !== 3'd0) begin n_fail++; $display("FAIL reset_pos got=%0d exp=0", pos); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    SW = 4'b0000;
  endtask

  task automatic test_hello();
    logic [31:0] hell;
`ifdef HEX_DP_MARK_EN
    hell = 32'h0986C7C7;
`else
    hell = 32'h8986C7C7;
`endif
    cyc();
    n_checks++; if (HEX !== hell) begin n_fail++; $display("FAIL hello_hex got=%h exp=%h", HEX, hell); end
    repeat (3) cyc();
    n_checks++; if (pos !== 3'd1 || pos !== m_pos) begin n_fail++; $display("FAIL hello_pos got=%0d exp=1 model=%0d", pos, m_pos); end
    cyc();
    n_checks++; if (HEX !== 32'h86C7C7C0) begin n_fail++; $display("FAIL ello_hex got=%h exp=86c7c7c0", HEX); end
  endtask

  task automatic test_wrap_left();
    int dut_wraps = 0;
    int mdl_wraps = 0;
    int n = 0;
    while (mdl_wraps == 0 && n < 64) begin
      cyc(); n++;
      if (wrap) dut_wraps++;
      if (m_wrap) mdl_wraps++;
      n_checks++; if (HEX !== m_hex || pos !== m_pos || wrap !== m_wrap) begin
        n_fail++; $display("FAIL wrap_left_cycle got=%h/%0d/%b exp=%h/%0d/%b", HEX, pos, wrap, m_hex, m_pos, m_wrap);
      end
    end
    n_checks++; if (mdl_wraps != 1 || dut_wraps != 1 || pos !== 3'd0) begin
      n_fail++; $display("FAIL wrap_left_pulse got wraps=%0d pos=%0d exp wraps=1 pos=0", dut_wraps, pos);
    end
    cyc();
    n_checks++; if (wrap !== 1'b0 || HEX !== m_hex) begin n_fail++; $display("FAIL wrap_left_after got=%b/%h exp=0/%h", wrap, HEX, m_hex); end
  endtask

  task automatic test_dir_right();
    logic [31:0] exp7;
    int n = 0;
`ifdef HEX_DP_MARK_EN
    exp7 = 32'hFF0986C7;
`else
    exp7 = 32'hFF8986C7;
`endif
    SW = 4'b0100;
    while (!m_wrap && n < 32) begin
      cyc(); n++;
      n_checks++; if (HEX !== m_hex || pos !== m_pos || wrap !== m_wrap) begin
        n_fail++; $display("FAIL dir_right_cycle got=%h/%0d/%b exp=%h/%0d/%b", HEX, pos, wrap, m_hex, m_pos, m_wrap);
      end
    end
    n_checks++; if (pos !== 3'd7 || wrap !== 1'b1) begin n_fail++; $display("FAIL dir_right_wrap got pos=%0d wrap=%b exp 7/1", pos, wrap); end
    cyc();
    n_checks++; if (HEX !== exp7) begin n_fail++; $display("FAIL dir_right_hex got=%h exp=%h", HEX, exp7); end
  endtask

  task automatic test_pause();
    logic [2:0] held;
    int n;
    SW = 4'b0010;
    repeat (3) cyc();
    held = pos;
    repeat (20) begin
      cyc();
      n_checks++; if (pos !== held || wrap !== 1'b0 || HEX !== m_hex || pos !== m_pos) begin
        n_fail++; $display("FAIL pause_hold got=%0d/%b/%h exp=%0d/0/%h", pos, wrap, HEX, held, m_hex);
      end
    end
    SW = 4'b0000;
    n = 0;
    while (pos === held && n < 20) begin cyc(); n++; end
    n_checks++; if (n != TD + 3 || pos !== m_pos) begin n_fail++; $display("FAIL pause_release got=%0d cycles pos=%0d exp=%0d cycles pos=%0d", n, pos, TD + 3, m_pos); end
    // pause lands exactly on the edge that would have stepped
    n = 0;
    while (!(m_mode == M_RUN && m_left == 3) && n < 20) begin cyc(); n++; end
    held = pos;
    SW = 4'b0010;
    repeat (3) cyc();
    n_checks++; if (pos !== held || wrap !== 1'b0 || pos !== m_pos) begin n_fail++; $display("FAIL pause_tick got=%0d/%b exp=%0d/0", pos, wrap, held); end
    SW = 4'b0000;
    repeat (10) begin
      cyc();
      n_checks++; if (HEX !== m_hex || pos !== m_pos || wrap !== m_wrap) begin
        n_fail++; $display("FAIL pause_resume got=%h/%0d/%b exp=%h/%0d/%b", HEX, pos, wrap, m_hex, m_pos, m_wrap);
      end
    end
  endtask

  task automatic test_oneshot();
    int n = 0;
    SW = 4'b1000;
    while (m_mode != M_DONE && n < 80) begin
      cyc(); n++;
      n_checks++; if (HEX !== m_hex || pos !== m_pos || wrap !== m_wrap) begin
        n_fail++; $display("FAIL oneshot_cycle got=%h/%0d/%b exp=%h/%0d/%b", HEX, pos, wrap, m_hex, m_pos, m_wrap);
      end
    end
    n_checks++; if (m_mode != M_DONE || wrap !== 1'b1) begin n_fail++; $display("FAIL oneshot_stop got wrap=%b exp=1", wrap); end
    repeat (12) begin
      cyc();
      n_checks++; if (HEX !== '1 || pos !== 3'd0 || wrap !== 1'b0) begin
        n_fail++; $display("FAIL oneshot_done got=%h/%0d/%b exp=ffffffff/0/0", HEX, pos, wrap);
      end
    end
    SW = 4'b0000;
    repeat (12) begin
      cyc();
      n_checks++; if (HEX !== m_hex || pos !== m_pos || wrap !== m_wrap) begin
        n_fail++; $display("FAIL oneshot_rerun got=%h/%0d/%b exp=%h/%0d/%b", HEX, pos, wrap, m_hex, m_pos, m_wrap);
      end
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    SW = 4'b0000;
    while (m_pos != 3'd3 && n < 64) begin cyc(); n++; end
    SW = 4'b0010;
    repeat (5) cyc();
    n_checks++; if (pos !== 3'd3) begin n_fail++; $display("FAIL async_setup got pos=%0d exp=3", pos); end
    #2 SW = 4'b0011;
    #1;
    n_checks++; if (HEX !== '1 || pos !== 3'd0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got=%h/%0d/%b exp=ffffffff/0/0", HEX, pos, wrap);
    end
    model_reset();
    repeat (2) cyc();
    SW = 4'b0000;
    cyc();
    n_checks++; if (HEX !== m_hex || pos !== 3'd0) begin n_fail++; $display("FAIL async_restart got=%h exp=%h", HEX, m_hex); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (SW[0]) SW[0] = 1'b0;
      else if ($urandom_range(0, 99) < 1) SW[0] = 1'b1;
      if ($urandom_range(0, 99) < 8) SW[3:1] = 3'($urandom_range(0, 7));
      cyc();
      n_checks++; if (HEX !== m_hex || pos !== m_pos || wrap !== m_wrap) begin
        n_fail++; $display("FAIL random_cycle%0d got=%h/%0d/%b exp=%h/%0d/%b", i, HEX, pos, wrap, m_hex, m_pos, m_wrap);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_hello();
    test_wrap_left();
    test_dir_right();
    test_pause();
    test_oneshot();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
